// File: rtl/ov7670_pkg.sv
// Shared FSM encoding and command constants for the OV7670 SCCB configuration path.
package ov7670_pkg;

   typedef logic [2:0] state_t;

   localparam state_t StIdle   = 3'd0;
   localparam state_t StSettle = 3'd1;
   localparam state_t StStart  = 3'd2;
   localparam state_t StBit    = 3'd3;
   localparam state_t StStop   = 3'd4;
   localparam state_t StAdv    = 3'd5;
   localparam state_t StDelay  = 3'd6;
   localparam state_t StDone   = 3'd7;

   localparam int unsigned SCCB_BITS = 27;
   localparam logic [15:0] CMD_DELAY = 16'hFFF0;
   localparam logic [15:0] CMD_END   = 16'hFFFF;

   // Bit index counts 26..0; every ninth bit is the don't-care ack slot.
   function automatic logic is_ack_bit(input logic [4:0] idx);
      return (idx == 5'd18) || (idx == 5'd9) || (idx == 5'd0);
   endfunction

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit divider for SCCB: one-cycle tick every DIV clocks while enabled.
module sccb_tick_gen #(
   parameter int unsigned DIV = 250
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("sccb_tick_gen: quarter-bit divider must be at least 2");
   end

   logic [CW-1:0] cnt_q;

   // Counter is held at zero while disabled so every phase starts on a full quarter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!enable || cnt_q == CntMax) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = enable && (cnt_q == CntMax);

endmodule

// File: rtl/ov7670_sccb_writer.sv
// Serialises OV7670 register-table entries as 3-phase SCCB writes.
// Optional delay-marker support is enabled by defining OV7670_SCCB_DELAY_EN.
module ov7670_sccb_writer
   import ov7670_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned SCCB_FREQ_HZ = 100_000,
   parameter logic [7:0]  DEV_ID       = 8'h42,
   parameter int unsigned DELAY_MS     = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] command,
   input  logic        finished,
   output logic        advance,
   output logic        sioc,
   output logic        siod_oe,
   output logic        busy,
   output logic        done,
   output logic [7:0]  nack_cnt,
   input  logic        siod_i
);

   localparam int unsigned QDIV = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
   localparam longint unsigned DelayCycles = 64'(DELAY_MS) * 64'(CLK_FREQ_HZ) / 64'd1000;

   if (DelayCycles >= 64'h1_0000_0000) begin : g_delay_check
      $error("ov7670_sccb_writer: delay length must fit a 32-bit cycle count");
   end

   state_t               state_q, state_d;
   logic [1:0]           qtr_q, qtr_d;
   logic [4:0]           bit_idx_q, bit_idx_d;
   logic [SCCB_BITS-1:0] shift_q, shift_d;
   logic [15:0]          cmd_q, cmd_d;
   logic                 settle_q, settle_d;
   logic [7:0]           nack_q, nack_d;
   logic                 sioc_q, sioc_d;
   logic                 siod_oe_q, siod_oe_d;
   logic                 tick, tick_en;

   assign tick_en = !(state_q inside {StIdle, StSettle, StDone});

   sccb_tick_gen #(
      .DIV (QDIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (tick_en),
      .tick   (tick)
   );

`ifdef OV7670_SCCB_DELAY_EN
   localparam int unsigned DW = (DelayCycles > 1) ? $clog2(DelayCycles) : 1;
   logic [DW-1:0] dly_q, dly_d;
`endif

   always_comb begin
      state_d   = state_q;
      qtr_d     = qtr_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      cmd_d     = cmd_q;
      settle_d  = 1'b0;
      nack_d    = nack_q;
`ifdef OV7670_SCCB_DELAY_EN
      dly_d     = '0;
`endif
      unique case (state_q)
         StIdle: state_d = StSettle;
         StSettle: begin
            // Second SETTLE cycle: table output has caught up with the address.
            settle_d = !settle_q;
            if (settle_q) begin
               cmd_d = command;
               if (finished) begin
                  state_d = StDone;
`ifdef OV7670_SCCB_DELAY_EN
               end else if (command == CMD_DELAY) begin
                  state_d = StDelay;
`endif
               end else begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            shift_d   = {DEV_ID, 1'b1, cmd_q[15:8], 1'b1, cmd_q[7:0], 1'b1};
            bit_idx_d = 5'(SCCB_BITS - 1);
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) state_d = StBit;
            end
         end
         StBit: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd2 && is_ack_bit(bit_idx_q) && siod_i && nack_q != 8'hFF) begin
                  nack_d = nack_q + 8'd1;
               end
               if (qtr_q == 2'd3) begin
                  shift_d = {shift_q[SCCB_BITS-2:0], 1'b0};
                  if (bit_idx_q == 5'd0) state_d = StStop;
                  else bit_idx_d = bit_idx_q - 5'd1;
               end
            end
         end
         StStop: begin
            if (tick) begin
               qtr_d = qtr_q + 2'd1;
               if (qtr_q == 2'd3) state_d = StAdv;
            end
         end
         StAdv: state_d = StSettle;
`ifdef OV7670_SCCB_DELAY_EN
         StDelay: begin
            dly_d = dly_q + 1'b1;
            if (dly_q == DW'(DelayCycles - 1)) begin
               dly_d   = '0;
               state_d = StAdv;
            end
         end
`endif
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   // Bus levels decoded from the current phase; registered so SIOC/SIOD never glitch.
   always_comb begin
      sioc_d    = 1'b1;
      siod_oe_d = 1'b0;
      unique case (state_q)
         StStart: begin
            sioc_d    = (qtr_q != 2'd3);
            siod_oe_d = qtr_q[1];
         end
         StBit: begin
            sioc_d    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
            siod_oe_d = !shift_q[SCCB_BITS-1];
         end
         StStop: begin
            sioc_d    = (qtr_q != 2'd0);
            siod_oe_d = !qtr_q[1];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         qtr_q     <= 2'd0;
         bit_idx_q <= 5'd0;
         shift_q   <= '0;
         cmd_q     <= 16'h0000;
         settle_q  <= 1'b0;
         nack_q    <= 8'd0;
         sioc_q    <= 1'b1;
         siod_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         cmd_q     <= cmd_d;
         settle_q  <= settle_d;
         nack_q    <= nack_d;
         sioc_q    <= sioc_d;
         siod_oe_q <= siod_oe_d;
      end
   end

`ifdef OV7670_SCCB_DELAY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly_q <= '0;
      else        dly_q <= dly_d;
   end
`endif

   assign advance  = (state_q == StAdv);
   assign busy     = !(state_q inside {StIdle, StDone});
   assign done     = (state_q == StDone);
   assign nack_cnt = nack_q;
   assign sioc     = sioc_q;
   assign siod_oe  = siod_oe_q;

endmodule

// File: tb/tb_ov7670_sccb_writer.sv
// Self-checking bench: decodes the SCCB bus and compares against a table-level model.
module tb_ov7670_sccb_writer;

   localparam int unsigned TB_CLK  = 1_000_000;
   localparam int unsigned TB_SCCB = 125_000;
   localparam int unsigned QD      = TB_CLK / (4 * TB_SCCB);
   localparam int unsigned ENTRY_CLKS = 116 * QD + 3;
   localparam logic [7:0]  TB_DEV  = 8'h42;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] command = 16'h0000;
   logic        finished = 1'b0;
   logic        advance, sioc, siod_oe, busy, done;
   logic [7:0]  nack_cnt;
   logic        siod_i = 1'b0;
   logic        line;

   int checks = 0;
   int failures = 0;

   ov7670_sccb_writer #(
      .CLK_FREQ_HZ  (TB_CLK),
      .SCCB_FREQ_HZ (TB_SCCB),
      .DEV_ID       (TB_DEV),
      .DELAY_MS     (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .command  (command),
      .finished (finished),
      .advance  (advance),
      .sioc     (sioc),
      .siod_oe  (siod_oe),
      .busy     (busy),
      .done     (done),
      .nack_cnt (nack_cnt),
      .siod_i   (siod_i)
   );

   always #5 clk = ~clk;

   assign line = ~siod_oe;

   // Bus monitor: start/stop detection and bit capture on SIOC rising edges.
   logic        prev_sioc = 1'b1;
   logic        prev_line = 1'b1;
   bit          in_frame = 1'b0;
   int          bitcnt = 0;
   int          sioc_edges = 0;
   logic [26:0] cur = '0;
   logic [26:0] frames[$];
   logic [15:0] tbl[$];
   logic [7:0]  nack_hist[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame  = 1'b0;
         bitcnt    = 0;
         prev_sioc = 1'b1;
         prev_line = 1'b1;
      end else begin
         if (sioc !== prev_sioc) sioc_edges++;
         if (prev_sioc && sioc && prev_line && !line) begin
            in_frame = 1'b1;
            bitcnt   = 0;
            cur      = '0;
         end else if (prev_sioc && sioc && !prev_line && line) begin
            // 27 data/ack clocks plus the clock that opens the stop condition.
            if (in_frame && bitcnt == 28) frames.push_back(cur);
            in_frame = 1'b0;
         end else if (!prev_sioc && sioc && in_frame) begin
            if (bitcnt < 27) cur = {cur[25:0], line};
            bitcnt++;
         end
         prev_sioc = sioc;
         prev_line = line;
      end
   end

   function automatic logic [26:0] exp_frame(input logic [15:0] c);
      return {TB_DEV, 1'b1, c[15:8], 1'b1, c[7:0], 1'b1};
   endfunction

   function automatic logic [15:0] rand_cmd();
      logic [15:0] c;
      do c = 16'($urandom); while (c == 16'hFFFF || c == 16'hFFF0);
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      siod_i = 1'b0;
      finished = 1'b0;
      repeat (3) step();
      frames.delete();
      sioc_edges = 0;
   endtask

   task automatic wait_adv(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         n++;
         if (advance) ok = 1'b1;
      end
   endtask

   // Table model: next entry presented as soon as advance is seen; FFFF ends it.
   task automatic run_table(input int budget, output int advs);
      int idx = 0;
      advs = 0;
      nack_hist.delete();
      command = tbl[0];
      finished = (command == 16'hFFFF);
      rst_n = 1'b1;
      for (int i = 0; i < budget && !done; i++) begin
         step();
         if (advance) begin
            advs++;
            nack_hist.push_back(nack_cnt);
            idx++;
            command = (idx < tbl.size()) ? tbl[idx] : 16'hFFFF;
            finished = (command == 16'hFFFF);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      checks++; if (sioc !== 1'b1) begin failures++; $display("FAIL reset_sioc got=%b exp=1", sioc); end
      checks++; if (siod_oe !== 1'b0) begin failures++; $display("FAIL reset_siod_oe got=%b exp=0", siod_oe); end
      checks++; if (advance !== 1'b0) begin failures++; $display("FAIL reset_advance got=%b exp=0", advance); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (nack_cnt !== 8'd0) begin failures++; $display("FAIL reset_nack got=%0d exp=0", nack_cnt); end
   endtask

   task automatic test_single_write();
      bit ok;
      int n;
      do_reset();
      command = 16'h1280;
      rst_n = 1'b1;
      wait_adv(2000, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL single_adv_timeout got=none exp=advance"); end
      checks++;
      if (frames.size() != 1 || frames[0] !== exp_frame(16'h1280)) begin
         failures++;
         $display("FAIL single_frame got_n=%0d got=%h exp=%h", frames.size(),
                  (frames.size() > 0) ? frames[0] : 27'h0, exp_frame(16'h1280));
      end
      step();
      checks++; if (advance !== 1'b0) begin failures++; $display("FAIL single_adv_width got=%b exp=0", advance); end
      wait_adv(2 * ENTRY_CLKS, ok, n);
      checks++;
      if (!ok || n != ENTRY_CLKS - 1) begin
         failures++;
         $display("FAIL entry_period got=%0d exp=%0d", n + 1, ENTRY_CLKS);
      end
   endtask

   task automatic test_table();
      int advs;
      int bad = 0;
      bit hold_done = 1, hold_busy = 1, hold_sioc = 1, hold_oe = 1;
      do_reset();
      tbl.delete();
      for (int i = 0; i < 3; i++) tbl.push_back(rand_cmd());
      tbl.push_back(16'hFFFF);
      run_table(4 * ENTRY_CLKS + 50, advs);
      checks++; if (advs != 3) begin failures++; $display("FAIL table_advs got=%0d exp=3", advs); end
      for (int i = 0; i < 3; i++) begin
         if (i >= frames.size() || frames[i] !== exp_frame(tbl[i])) bad++;
      end
      checks++;
      if (bad != 0 || frames.size() != 3) begin
         failures++;
         $display("FAIL table_frames got_n=%0d bad=%0d exp_n=3 bad=0", frames.size(), bad);
      end
      for (int i = 0; i < 40; i++) begin
         step();
         if (done !== 1'b1) hold_done = 0;
         if (busy !== 1'b0) hold_busy = 0;
         if (sioc !== 1'b1) hold_sioc = 0;
         if (siod_oe !== 1'b0) hold_oe = 0;
      end
      checks++; if (!hold_done) begin failures++; $display("FAIL done_held got=%b exp=1", done); end
      checks++; if (!hold_busy) begin failures++; $display("FAIL busy_after_done got=%b exp=0", busy); end
      checks++; if (!hold_sioc) begin failures++; $display("FAIL sioc_after_done got=%b exp=1", sioc); end
      checks++; if (!hold_oe) begin failures++; $display("FAIL oe_after_done got=%b exp=0", siod_oe); end
   endtask

   task automatic test_delay();
      bit ok;
      int n;
      do_reset();
      command = 16'hFFF0;
      rst_n = 1'b1;
`ifdef OV7670_SCCB_DELAY_EN
      wait_adv(3000, ok, n);
      checks++;
      if (!ok || n < 1000 || n > 1006) begin
         failures++;
         $display("FAIL delay_length got=%0d exp=1000..1006", n);
      end
      checks++; if (sioc_edges != 0) begin failures++; $display("FAIL delay_sioc_edges got=%0d exp=0", sioc_edges); end
      checks++; if (frames.size() != 0) begin failures++; $display("FAIL delay_frames got=%0d exp=0", frames.size()); end
`else
      wait_adv(2000, ok, n);
      checks++; if (!ok) begin failures++; $display("FAIL marker_adv_timeout got=none exp=advance"); end
      checks++;
      if (frames.size() != 1 || frames[0] !== exp_frame(16'hFFF0)) begin
         failures++;
         $display("FAIL marker_frame got_n=%0d exp=%h", frames.size(), exp_frame(16'hFFF0));
      end
`endif
   endtask

   task automatic test_nack();
      int advs;
      int bad = 0;
      int hist_bad = 0;
      do_reset();
      siod_i = 1'b1;
      tbl.delete();
      for (int i = 0; i < 100; i++) tbl.push_back(rand_cmd());
      tbl.push_back(16'hFFFF);
      run_table(101 * ENTRY_CLKS + 100, advs);
      checks++; if (advs != 100) begin failures++; $display("FAIL nack_advs got=%0d exp=100", advs); end
      checks++; if (nack_cnt !== 8'd255) begin failures++; $display("FAIL nack_sat got=%0d exp=255", nack_cnt); end
      for (int k = 0; k < nack_hist.size(); k++) begin
         if (int'(nack_hist[k]) != ((3 * (k + 1) > 255) ? 255 : 3 * (k + 1))) hist_bad++;
      end
      checks++;
      if (hist_bad != 0 || nack_hist.size() != 100) begin
         failures++;
         $display("FAIL nack_progress got_bad=%0d n=%0d exp_bad=0 n=100", hist_bad, nack_hist.size());
      end
      for (int i = 0; i < 100; i++) begin
         if (i >= frames.size() || frames[i] !== exp_frame(tbl[i])) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL nack_frames got_bad=%0d exp=0", bad); end
      siod_i = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      int guard = 0;
      logic [15:0] b;
      do_reset();
      command = rand_cmd();
      b = rand_cmd();
      rst_n = 1'b1;
      while (!(in_frame && bitcnt >= 13) && guard < 2000) begin
         step();
         guard++;
      end
      checks++; if (guard >= 2000) begin failures++; $display("FAIL midrst_reach got=timeout exp=bit13"); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (sioc !== 1'b1 || siod_oe !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midrst_snap got=%b%b%b exp=100", sioc, siod_oe, busy);
      end
      step();
      step();
      frames.delete();
      command = b;
      rst_n = 1'b1;
      wait_adv(2000, ok, n);
      checks++;
      if (!ok || frames.size() != 1 || frames[0] !== exp_frame(b)) begin
         failures++;
         $display("FAIL midrst_restart got_n=%0d exp=%h", frames.size(), exp_frame(b));
      end
   endtask

   task automatic test_cmd_change();
      bit ok;
      int n;
      int guard = 0;
      logic [15:0] a, b;
      do_reset();
      a = rand_cmd();
      do b = rand_cmd(); while (b == a);
      command = a;
      rst_n = 1'b1;
      while (!(in_frame && bitcnt >= 5) && guard < 2000) begin
         step();
         guard++;
      end
      command = b;
      wait_adv(2000, ok, n);
      checks++;
      if (!ok || frames.size() != 1 || frames[0] !== exp_frame(a)) begin
         failures++;
         $display("FAIL latch_cmd got_n=%0d got=%h exp=%h", frames.size(),
                  (frames.size() > 0) ? frames[0] : 27'h0, exp_frame(a));
      end
      wait_adv(2 * ENTRY_CLKS, ok, n);
      checks++;
      if (!ok || frames.size() != 2 || frames[1] !== exp_frame(b)) begin
         failures++;
         $display("FAIL next_cmd got_n=%0d exp=%h", frames.size(), exp_frame(b));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_write();
      test_table();
      test_delay();
      test_nack();
      test_reset_mid();
      test_cmd_change();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
